// File: rtl/dispatch_ctrl.sv
// Issue sequencer between the decoder and the ROB/RS/LSB/rename back-end.
// Latency: issue and redirect pulses appear one edge after the instruction is accepted (or released from HOLD/JWAIT).
// Backpressure: ifetch_stall is combinational and holds fetch while any needed resource is full or a JALR base is outstanding.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rdy                       global ready; low freezes state and held data, pulses drop to 0
//   rollback                  misprediction flush; discards held instruction and JALR wait
//   dec_*                     decoded instruction fields (resource needs, JALR operands)
//   rob_full/rs_full/lsb_full back-end resource full flags
//   alu_*/lsb_rob_*/lsb_value result broadcast buses snooped for the JALR base
//   ifetch_stall              combinational fetch hold
//   *_issue, redirect         registered one-cycle pulses
//   redirect_pc               registered JALR target, bit 0 cleared
//   state                     IDLE=0, HOLD=1, JWAIT=2
module dispatch_ctrl #(
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             dec_valid,
  input  logic             dec_to_rs,
  input  logic             dec_to_lsb,
  input  logic             dec_to_rf,
  input  logic             dec_is_jalr,
  input  logic             dec_jalr_rdy,
  input  logic [XLEN-1:0]  dec_jalr_base,
  input  logic [ROB_W-1:0] dec_jalr_rob,
  input  logic [XLEN-1:0]  dec_jalr_off,
  input  logic             rob_full,
  input  logic             rs_full,
  input  logic             lsb_full,
  input  logic             alu_rob_config,
  input  logic [ROB_W-1:0] alu_rob_entry,
  input  logic [XLEN-1:0]  alu_value,
  input  logic             lsb_rob_config,
  input  logic [ROB_W-1:0] lsb_rob_entry,
  input  logic [XLEN-1:0]  lsb_value,
  output logic             ifetch_stall,
  output logic             rob_issue,
  output logic             rs_issue,
  output logic             lsb_issue,
  output logic             rf_issue,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    JWAIT = 2'd2
  } state_t;

  state_t cur;
  assign state = cur;

  // Held copy of a blocked instruction. The tag/offset pair doubles as the
  // wait record while in JWAIT.
  logic             h_rs;
  logic             h_lsb;
  logic             h_rf;
  logic             h_jalr;
  logic             h_jrdy;
  logic [XLEN-1:0]  h_base;
  logic [ROB_W-1:0] h_tag;
  logic [XLEN-1:0]  h_off;

  // Broadcast snoop against the held tag; ALU wins when both buses hit.
  logic            alu_hit;
  logic            lsb_hit;
  logic            snoop_hit;
  logic [XLEN-1:0] snoop_val;

  assign alu_hit   = alu_rob_config && (alu_rob_entry == h_tag);
  assign lsb_hit   = lsb_rob_config && (lsb_rob_entry == h_tag);
  assign snoop_hit = alu_hit | lsb_hit;
  assign snoop_val = alu_hit ? alu_value : lsb_value;

  logic dec_blocked;
  logic held_blocked;
  assign dec_blocked  = rob_full | (dec_to_rs & rs_full) | (dec_to_lsb & lsb_full);
  assign held_blocked = rob_full | (h_rs & rs_full) | (h_lsb & lsb_full);

  // A held JALR released in the same cycle its base is broadcast uses the
  // bus value directly, so the broadcast is never lost on the way to JWAIT.
  logic            held_jrdy_eff;
  logic [XLEN-1:0] held_base_eff;
  assign held_jrdy_eff = h_jrdy | snoop_hit;
  assign held_base_eff = h_jrdy ? h_base : snoop_val;

  // Only the IDLE term matters below; any other state stalls regardless.
  assign ifetch_stall = (cur != IDLE) |
                        (dec_valid & (dec_blocked | (dec_is_jalr & ~dec_jalr_rdy)));

  function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] base,
                                                  input logic [XLEN-1:0] off);
    logic [XLEN-1:0] sum;
    sum = base + off;
    return {sum[XLEN-1:1], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= IDLE;
      rob_issue   <= 1'b0;
      rs_issue    <= 1'b0;
      lsb_issue   <= 1'b0;
      rf_issue    <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      h_rs        <= 1'b0;
      h_lsb       <= 1'b0;
      h_rf        <= 1'b0;
      h_jalr      <= 1'b0;
      h_jrdy      <= 1'b0;
      h_base      <= '0;
      h_tag       <= '0;
      h_off       <= '0;
    end else if (rollback) begin
      cur       <= IDLE;
      rob_issue <= 1'b0;
      rs_issue  <= 1'b0;
      lsb_issue <= 1'b0;
      rf_issue  <= 1'b0;
      redirect  <= 1'b0;
      h_rs      <= 1'b0;
      h_lsb     <= 1'b0;
      h_rf      <= 1'b0;
      h_jalr    <= 1'b0;
      h_jrdy    <= 1'b0;
      h_base    <= '0;
      h_tag     <= '0;
      h_off     <= '0;
    end else if (!rdy) begin
      // Freeze everything except the pulses, which must not repeat.
      rob_issue <= 1'b0;
      rs_issue  <= 1'b0;
      lsb_issue <= 1'b0;
      rf_issue  <= 1'b0;
      redirect  <= 1'b0;
    end else begin
      rob_issue <= 1'b0;
      rs_issue  <= 1'b0;
      lsb_issue <= 1'b0;
      rf_issue  <= 1'b0;
      redirect  <= 1'b0;
      case (cur)
        IDLE: begin
          if (dec_valid) begin
            if (dec_blocked) begin
              h_rs   <= dec_to_rs;
              h_lsb  <= dec_to_lsb;
              h_rf   <= dec_to_rf;
              h_jalr <= dec_is_jalr;
              h_jrdy <= dec_jalr_rdy;
              h_base <= dec_jalr_base;
              h_tag  <= dec_jalr_rob;
              h_off  <= dec_jalr_off;
              cur    <= HOLD;
            end else begin
              rob_issue <= 1'b1;
              rs_issue  <= dec_to_rs;
              lsb_issue <= dec_to_lsb;
              rf_issue  <= dec_to_rf;
              if (dec_is_jalr) begin
                if (dec_jalr_rdy) begin
                  redirect    <= 1'b1;
                  redirect_pc <= jalr_target(dec_jalr_base, dec_jalr_off);
                end else begin
                  h_tag <= dec_jalr_rob;
                  h_off <= dec_jalr_off;
                  cur   <= JWAIT;
                end
              end
            end
          end
        end

        HOLD: begin
          if (held_blocked) begin
            if (h_jalr && !h_jrdy && snoop_hit) begin
              h_jrdy <= 1'b1;
              h_base <= snoop_val;
            end
          end else begin
            rob_issue <= 1'b1;
            rs_issue  <= h_rs;
            lsb_issue <= h_lsb;
            rf_issue  <= h_rf;
            if (h_jalr && !held_jrdy_eff) begin
              // Tag and offset are already held for the wait.
              cur <= JWAIT;
            end else begin
              if (h_jalr) begin
                redirect    <= 1'b1;
                redirect_pc <= jalr_target(held_base_eff, h_off);
              end
              cur <= IDLE;
            end
          end
        end

        JWAIT: begin
          if (snoop_hit) begin
            redirect    <= 1'b1;
            redirect_pc <= jalr_target(snoop_val, h_off);
            cur         <= IDLE;
          end
        end

        default: cur <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed vector table, hand-written
// corner sequences, then randomized stimulus against a queue-based model.
module tb_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        dec_valid, dec_to_rs, dec_to_lsb, dec_to_rf, dec_is_jalr, dec_jalr_rdy;
  logic [31:0] dec_jalr_base, dec_jalr_off;
  logic [3:0]  dec_jalr_rob;
  logic        rob_full, rs_full, lsb_full;
  logic        alu_rob_config, lsb_rob_config;
  logic [3:0]  alu_rob_entry, lsb_rob_entry;
  logic [31:0] alu_value, lsb_value;
  logic        ifetch_stall, rob_issue, rs_issue, lsb_issue, rf_issue, redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  state;

  dispatch_ctrl #(.ROB_W(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .dec_valid(dec_valid), .dec_to_rs(dec_to_rs), .dec_to_lsb(dec_to_lsb),
    .dec_to_rf(dec_to_rf), .dec_is_jalr(dec_is_jalr), .dec_jalr_rdy(dec_jalr_rdy),
    .dec_jalr_base(dec_jalr_base), .dec_jalr_rob(dec_jalr_rob), .dec_jalr_off(dec_jalr_off),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .alu_rob_config(alu_rob_config), .alu_rob_entry(alu_rob_entry), .alu_value(alu_value),
    .lsb_rob_config(lsb_rob_config), .lsb_rob_entry(lsb_rob_entry), .lsb_value(lsb_value),
    .ifetch_stall(ifetch_stall), .rob_issue(rob_issue), .rs_issue(rs_issue),
    .lsb_issue(lsb_issue), .rf_issue(rf_issue), .redirect(redirect),
    .redirect_pc(redirect_pc), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit          rs, lsb, rf, jalr, jrdy;
    logic [31:0] base;
    logic [3:0]  tag;
    logic [31:0] off;
  } insn_t;

  insn_t       pend[$];      // at most one instruction waiting for resources
  bit          w_v;          // a JALR waiting for its base
  logic [3:0]  w_tag;
  logic [31:0] w_off;
  bit          e_rob, e_rs, e_lsb, e_rf, e_red;
  logic [31:0] e_pc;
  logic [1:0]  e_state;
  bit          m_stall;

  function automatic insn_t cur_dec();
    insn_t p;
    p.rs = dec_to_rs; p.lsb = dec_to_lsb; p.rf = dec_to_rf; p.jalr = dec_is_jalr;
    p.jrdy = dec_jalr_rdy; p.base = dec_jalr_base; p.tag = dec_jalr_rob; p.off = dec_jalr_off;
    return p;
  endfunction

  function automatic bit blocked(input insn_t p);
    return rob_full || (p.rs && rs_full) || (p.lsb && lsb_full);
  endfunction

  task automatic bcast(input logic [3:0] t, output bit hit, output logic [31:0] val);
    hit = 1'b0; val = 32'h0;
    if (alu_rob_config && alu_rob_entry == t) begin hit = 1'b1; val = alu_value; end
    else if (lsb_rob_config && lsb_rob_entry == t) begin hit = 1'b1; val = lsb_value; end
  endtask

  task automatic m_issue(input insn_t p);
    e_rob = 1'b1; e_rs = p.rs; e_lsb = p.lsb; e_rf = p.rf;
    if (p.jalr) begin
      if (p.jrdy) begin e_red = 1'b1; e_pc = (p.base + p.off) & ~32'h1; end
      else begin w_v = 1'b1; w_tag = p.tag; w_off = p.off; end
    end
  endtask

  function automatic bit model_stall();
    insn_t p;
    if (pend.size() != 0 || w_v) return 1'b1;
    p = cur_dec();
    return dec_valid && (blocked(p) || (p.jalr && !p.jrdy));
  endfunction

  task automatic model_edge();
    insn_t p; bit hit; logic [31:0] val;
    e_rob = 0; e_rs = 0; e_lsb = 0; e_rf = 0; e_red = 0;
    if (rst) begin
      pend.delete(); w_v = 0; e_pc = 32'h0;
    end else if (rollback) begin
      pend.delete(); w_v = 0;
    end else if (rdy) begin
      if (w_v) begin
        bcast(w_tag, hit, val);
        if (hit) begin e_red = 1; e_pc = (val + w_off) & ~32'h1; w_v = 0; end
      end else if (pend.size() != 0) begin
        p = pend.pop_front();
        if (p.jalr && !p.jrdy) begin
          bcast(p.tag, hit, val);
          if (hit) begin p.jrdy = 1; p.base = val; end
        end
        if (blocked(p)) pend.push_back(p); else m_issue(p);
      end else if (dec_valid) begin
        p = cur_dec();
        if (blocked(p)) pend.push_back(p); else m_issue(p);
      end
    end
    e_state = (pend.size() != 0) ? 2'd1 : (w_v ? 2'd2 : 2'd0);
  endtask

  // One clock: combinational stall sampled at the falling edge, registered
  // outputs sampled 1 ns after the rising edge. Inputs change only after that.
  logic stall_seen;
  task automatic tick();
    @(negedge clk);
    stall_seen = ifetch_stall;
    m_stall = model_stall();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clr();
    rst = 0; rdy = 1; rollback = 0;
    dec_valid = 0; dec_to_rs = 0; dec_to_lsb = 0; dec_to_rf = 0; dec_is_jalr = 0;
    dec_jalr_rdy = 0; dec_jalr_base = 0; dec_jalr_rob = 0; dec_jalr_off = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0;
    alu_rob_config = 0; alu_rob_entry = 0; alu_value = 0;
    lsb_rob_config = 0; lsb_rob_entry = 0; lsb_value = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    bit          rdy, rollback, valid, rs, lsb, rf, jalr, jrdy;
    logic [31:0] base;
    logic [3:0]  tag;
    logic [31:0] off;
    bit          robf, rsf, lsbf, av;
    logic [3:0]  ae;
    logic [31:0] aval;
    bit          lv;
    logic [3:0]  le;
    logic [31:0] lval;
    bit          x_stall, x_rob, x_rs, x_lsb, x_rf, x_red;
    logic [31:0] x_pc;
    logic [1:0]  x_st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t nop();
    vec_t v = '0;
    v.rdy = 1;
    return v;
  endfunction

  function automatic vec_t dec(bit rs, bit lsb, bit rf, bit jalr, bit jrdy,
                               logic [31:0] base, logic [3:0] tag, logic [31:0] off);
    vec_t v = nop();
    v.valid = 1; v.rs = rs; v.lsb = lsb; v.rf = rf; v.jalr = jalr; v.jrdy = jrdy;
    v.base = base; v.tag = tag; v.off = off;
    return v;
  endfunction

  function automatic vec_t ex(vec_t vi, bit stall, bit rob, bit rs, bit lsb, bit rf,
                              bit red, logic [31:0] pc, logic [1:0] st);
    vec_t v = vi;
    v.x_stall = stall; v.x_rob = rob; v.x_rs = rs; v.x_lsb = lsb; v.x_rf = rf;
    v.x_red = red; v.x_pc = pc; v.x_st = st;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst = 0; rdy = v.rdy; rollback = v.rollback;
    dec_valid = v.valid; dec_to_rs = v.rs; dec_to_lsb = v.lsb; dec_to_rf = v.rf;
    dec_is_jalr = v.jalr; dec_jalr_rdy = v.jrdy; dec_jalr_base = v.base;
    dec_jalr_rob = v.tag; dec_jalr_off = v.off;
    rob_full = v.robf; rs_full = v.rsf; lsb_full = v.lsbf;
    alu_rob_config = v.av; alu_rob_entry = v.ae; alu_value = v.aval;
    lsb_rob_config = v.lv; lsb_rob_entry = v.le; lsb_value = v.lval;
  endtask

  task automatic chk_outs(input string tag, input bit rob, input bit rs, input bit lsb,
                          input bit rf, input bit red, input logic [31:0] pc,
                          input logic [1:0] st);
    chk({tag, "_rob"}, rob_issue, rob);
    chk({tag, "_rs"}, rs_issue, rs);
    chk({tag, "_lsb"}, lsb_issue, lsb);
    chk({tag, "_rf"}, rf_issue, rf);
    chk({tag, "_redirect"}, redirect, red);
    if (red) chk({tag, "_pc"}, redirect_pc, pc);
    chk({tag, "_state"}, state, st);
  endtask

  initial begin
    vec_t v;

    // ADDI, all resources free
    tbl.push_back(ex(dec(1,0,1,0,0,0,0,0), 0, 1,1,0,1, 0,0, 0));
    tbl.push_back(ex(nop(),                0, 0,0,0,0, 0,0, 0));
    // Load held by lsb_full for three cycles
    v = dec(0,1,1,0,0,0,0,0); v.lsbf = 1; tbl.push_back(ex(v, 1, 0,0,0,0, 0,0, 1));
    v = nop(); v.lsbf = 1;                tbl.push_back(ex(v, 1, 0,0,0,0, 0,0, 1));
    v = nop(); v.lsbf = 1;                tbl.push_back(ex(v, 1, 0,0,0,0, 0,0, 1));
    tbl.push_back(ex(nop(), 1, 1,0,1,1, 0,0, 0));
    tbl.push_back(ex(nop(), 0, 0,0,0,0, 0,0, 0));
    // JALR with base ready
    tbl.push_back(ex(dec(0,0,1,1,1,32'h1003,0,32'h10), 0, 1,0,0,1, 1,32'h1012, 0));
    // JALR waiting on tag 5, both buses hit; ALU value wins
    tbl.push_back(ex(dec(0,0,1,1,0,0,5,32'hFFFF_FFFC), 1, 1,0,0,1, 0,0, 2));
    v = nop(); v.av = 1; v.ae = 5; v.aval = 32'h2000; v.lv = 1; v.le = 5; v.lval = 32'h3000;
    tbl.push_back(ex(v, 1, 0,0,0,0, 1,32'h1FFC, 0));
    // JALR tag 3 held by rob_full; LSB broadcast captured during HOLD
    v = dec(0,0,1,1,0,0,3,32'h20); v.robf = 1; tbl.push_back(ex(v, 1, 0,0,0,0, 0,0, 1));
    v = nop(); v.robf = 1; v.lv = 1; v.le = 3; v.lval = 32'h400;
    tbl.push_back(ex(v, 1, 0,0,0,0, 0,0, 1));
    v = nop(); v.robf = 1; v.av = 1; v.ae = 7; v.aval = 32'h999;
    tbl.push_back(ex(v, 1, 0,0,0,0, 0,0, 1));
    tbl.push_back(ex(nop(), 1, 1,0,0,1, 1,32'h420, 0));
    // JWAIT resolved by LSB bus while ALU carries another tag
    tbl.push_back(ex(dec(0,0,1,1,0,0,9,32'h8), 1, 1,0,0,1, 0,0, 2));
    v = nop(); v.av = 1; v.ae = 8; v.aval = 32'h1234; v.lv = 1; v.le = 9; v.lval = 32'h5001;
    tbl.push_back(ex(v, 1, 0,0,0,0, 1,32'h5008, 0));
    // Full flags of unneeded resources do not block
    v = dec(0,0,1,0,0,0,0,0); v.rsf = 1; v.lsbf = 1; tbl.push_back(ex(v, 0, 1,0,0,1, 0,0, 0));
    v = dec(1,0,0,0,0,0,0,0); v.rsf = 1;            tbl.push_back(ex(v, 1, 0,0,0,0, 0,0, 1));
    tbl.push_back(ex(nop(), 1, 1,1,0,0, 0,0, 0));
    // Target wraps modulo 2^32 and bit 0 is cleared
    tbl.push_back(ex(dec(0,0,0,1,1,32'hFFFF_FFFF,0,32'h2), 0, 1,0,0,0, 1,32'h0, 0));
    // JWAIT ignores a matching tag without a valid strobe
    tbl.push_back(ex(dec(0,0,0,1,0,0,4,0), 1, 1,0,0,0, 0,0, 2));
    v = nop(); v.ae = 4; v.aval = 32'h55;
    tbl.push_back(ex(v, 1, 0,0,0,0, 0,0, 2));
    v = nop(); v.av = 1; v.ae = 4; v.aval = 32'h77;
    tbl.push_back(ex(v, 1, 0,0,0,0, 1,32'h76, 0));

    // Reset
    clr(); rst = 1;
    tick(); tick();
    chk("reset_stall", stall_seen, 1'b0);
    chk_outs("reset", 0,0,0,0, 0,0, 0);
    chk("reset_pc", redirect_pc, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      tick();
      chk($sformatf("v%0d_stall", i), stall_seen, tbl[i].x_stall);
      chk_outs($sformatf("v%0d", i), tbl[i].x_rob, tbl[i].x_rs, tbl[i].x_lsb,
               tbl[i].x_rf, tbl[i].x_red, tbl[i].x_pc, tbl[i].x_st);
    end

    // Rollback coinciding with a matching broadcast in JWAIT
    clr(); dec_valid = 1; dec_is_jalr = 1; dec_jalr_rob = 4'd2; tick();
    chk_outs("rb_enter", 1,0,0,0, 0,0, 2);
    clr(); rollback = 1; alu_rob_config = 1; alu_rob_entry = 4'd2; alu_value = 32'h100; tick();
    chk_outs("rb_flush", 0,0,0,0, 0,0, 0);
    clr(); alu_rob_config = 1; alu_rob_entry = 4'd2; alu_value = 32'h100; tick();
    chk_outs("rb_after", 0,0,0,0, 0,0, 0);

    // rdy low across the HOLD release: one issue only once rdy returns
    clr(); dec_valid = 1; dec_to_lsb = 1; lsb_full = 1; tick();
    chk_outs("rdy_hold", 0,0,0,0, 0,0, 1);
    clr(); rdy = 0; tick();
    chk_outs("rdy_low1", 0,0,0,0, 0,0, 1);
    tick();
    chk_outs("rdy_low2", 0,0,0,0, 0,0, 1);
    clr(); tick();
    chk_outs("rdy_back", 1,0,1,0, 0,0, 0);
    tick();
    chk_outs("rdy_once", 0,0,0,0, 0,0, 0);

    // rdy low in IDLE: instruction is not taken
    clr(); rdy = 0; dec_valid = 1; dec_to_rf = 1; tick();
    chk("rdy_idle_stall", stall_seen, 1'b0);
    chk_outs("rdy_idle", 0,0,0,0, 0,0, 0);

    // Reset while holding
    clr(); dec_valid = 1; rob_full = 1; tick();
    chk_outs("rst_hold", 0,0,0,0, 0,0, 1);
    clr(); rst = 1; tick();
    chk_outs("rst_mid", 0,0,0,0, 0,0, 0);
    chk("rst_mid_pc", redirect_pc, 32'h0);

    // Randomized run against the model
    for (int c = 0; c < 4000; c++) begin
      clr();
      rst            = ($urandom_range(0, 199) == 0);
      rollback       = ($urandom_range(0, 29) == 0);
      rdy            = ($urandom_range(0, 6) != 0);
      dec_valid      = ($urandom_range(0, 9) < 6);
      dec_to_rs      = $urandom_range(0, 1);
      dec_to_lsb     = $urandom_range(0, 1);
      dec_to_rf      = $urandom_range(0, 1);
      dec_is_jalr    = ($urandom_range(0, 3) == 0);
      dec_jalr_rdy   = $urandom_range(0, 1);
      dec_jalr_base  = $urandom;
      dec_jalr_rob   = 4'($urandom_range(0, 3));
      dec_jalr_off   = $urandom;
      rob_full       = ($urandom_range(0, 4) == 0);
      rs_full        = ($urandom_range(0, 3) == 0);
      lsb_full       = ($urandom_range(0, 3) == 0);
      alu_rob_config = ($urandom_range(0, 9) < 3);
      alu_rob_entry  = 4'($urandom_range(0, 3));
      alu_value      = $urandom;
      lsb_rob_config = ($urandom_range(0, 9) < 3);
      lsb_rob_entry  = 4'($urandom_range(0, 3));
      lsb_value      = $urandom;
      tick();
      chk($sformatf("rnd%0d_stall", c), stall_seen, m_stall);
      chk_outs($sformatf("rnd%0d", c), e_rob, e_rs, e_lsb, e_rf, e_red, e_pc, e_state);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
